branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Resolution side of the fetch-stage BTB/2-bit-counter predictor.
- Records each fetch-stage prediction in an in-order tracking FIFO and retires the matching record when the instruction reaches EX.
- Compares predicted next-PC against actual next-PC, generates the predictor update port (resolved/taken/PC/target) and the pipeline redirect/flush.
- Keeps saturating branch and mispredict statistics.

Parameters:
- DEPTH, 4, number of in-flight prediction records between IF and EX; power of two.
- PTR_W, 2, log2(DEPTH).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetch issued an instruction this cycle; pushes a record
- if_pc  in  32  PC of the fetched instruction
- if_pred_npc  in  32  predictor's next-PC output for if_pc
- ex_valid  in  1  instruction in EX this cycle; pops the head record
- ex_pc  in  32  PC of the EX instruction
- ex_is_ctrl  in  1  EX instruction is a branch/jump
- ex_taken  in  1  actual branch outcome; don't-care if !ex_is_ctrl
- ex_target  in  32  actual taken target
- upd_valid  out  1  to predictor BranchResolved
- upd_taken  out  1  to predictor BranchTaken
- upd_pc  out  32  to predictor ResolvedBranchPC
- upd_target  out  32  to predictor ActualBranchTarget
- redirect  out  1  mispredict: flush IF/ID, load redirect_pc
- redirect_pc  out  32  correct next PC
- fifo_full  out  1  fetch must stall
- desync_err  out  1  sticky: pop on empty, PC mismatch or push on full
- branch_cnt  out  CNT_W  resolved control instructions, saturating
- mispred_cnt  out  CNT_W  redirects issued, saturating

Behaviour:
- Reset values:
  - FIFO empty; pointers 0; count 0.
  - desync_err 0; both counters 0.
  - All combinational outputs 0 while ex_valid = 0.
- FIFO entry fields: {pc[31:0], pred_npc[31:0]}.
- Circular buffer: rd/wr pointers of PTR_W bits wrap modulo DEPTH; occupancy count is PTR_W+1 bits.
- fifo_full = (count == DEPTH); registered-state-derived, no combinational path from inputs.
- Actual next-PC: anpc = (ex_is_ctrl & ex_taken) ? ex_target : ex_pc + 32'd4 (mod 2^32).
- Mispredict when ex_valid & !empty & (head.pred_npc != anpc). This also covers a non-control instruction with a stale taken BTB hit.
- Combinational, same cycle as ex_valid; zero latency, because the predictor samples at the negative edge of the same cycle:
  - upd_valid = ex_valid & ex_is_ctrl.
  - upd_taken = ex_taken; upd_pc = ex_pc; upd_target = ex_target.
  - redirect = mispredict; redirect_pc = anpc.
- Upd_* must not depend on FIFO state, so the predictor is still trained on desync.
- Posedge update order:
  - reset > redirect > normal operation.
  - On redirect: FIFO cleared (rd=wr=0, count=0). The same-cycle if_valid push is discarded, since it is a wrong-path fetch.
  - Normal: pop if ex_valid & !empty; push if if_valid & (!full | pop).
  - Push and pop in the same cycle when full is allowed; count is unchanged.
- desync_err set, and held until reset, when any of:
  - ex_valid while empty (no pop);
  - ex_valid & head.pc != ex_pc (record still popped, compare still performed);
  - if_valid while full without a same-cycle pop (push dropped).
- Counters, saturating at all-ones:
  - branch_cnt += 1 when upd_valid.
  - mispred_cnt += 1 when redirect.
- Stall handling: caller deasserts if_valid/ex_valid on stalled cycles; the block has no stall input.
- Reset mid-operation: all state is cleared on that edge. In-flight records are lost with no error flagged.

Decomposition:
- Shared package bp_pkg holds:
  - XLEN = 32, INSN_BYTES = 4;
  - the bp_update_t struct {valid, taken, pc, target}, shared with the predictor's update port;
  - the pred_rec_t struct {pc, pred_npc}.
- One natural sub-module, bru_track_fifo: parameterised DEPTH circular FIFO with push/pop/clear, full/empty, and head output.
- Compare, redirect and counter logic stay in the top level.

Test Plan:
- Reset, then idle 3 cycles -> fifo_full=0, desync_err=0, branch_cnt=mispred_cnt=0, upd_valid=redirect=0.
- Push pc=0x100 with pred 0x104, then ex_valid pc=0x100, non-control -> no redirect, no upd_valid, FIFO empty after.
- Push pc=0x200 with pred 0x204; EX branch taken, target 0x280 -> upd_valid=1, upd_taken=1, upd_pc=0x200, upd_target=0x280, redirect=1, redirect_pc=0x280, mispred_cnt=1. A same-cycle push of 0x204 is discarded; FIFO empty.
- Push pc=0x300 with pred 0x340; EX branch not-taken -> redirect_pc=0x304, upd_taken=0; branch_cnt increments.
- Push 4 records -> fifo_full=1. A 5th push with no pop is dropped and desync_err=1; a push concurrent with a pop while full is accepted, count stays 4.
- ex_valid with ex_pc=0x500 while the head pc is 0x400 -> desync_err=1, record popped, and upd_* still reflects the EX inputs. Force 2^CNT_W redirects -> mispred_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-prediction types.
// XLEN / INSN_BYTES: architectural widths used by the fetch and resolve paths.
// bp_update_t: the predictor's update port {valid, taken, pc, target}.
// pred_rec_t: one fetch-time prediction record {pc, pred_npc}.
package bp_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

  typedef struct packed {
    logic            valid;
    logic            taken;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } bp_update_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pred_npc;
  } pred_rec_t;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between the pipeline/predictor and branch_resolve_unit.
// master: pipeline side (drives IF/EX signals, observes update/redirect/status).
// slave : branch_resolve_unit.
// Handshake: if_valid and ex_valid are single-cycle strobes with no ready;
// the caller stalls fetch while fifo_full is high and deasserts both strobes
// on stalled cycles. upd_* and redirect are valid in the same cycle as ex_valid.
interface branch_resolve_unit_if #(parameter int CNT_W = 16);
  logic              if_valid;
  logic [31:0]       if_pc;
  logic [31:0]       if_pred_npc;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic              ex_is_ctrl;
  logic              ex_taken;
  logic [31:0]       ex_target;
  logic              upd_valid;
  logic              upd_taken;
  logic [31:0]       upd_pc;
  logic [31:0]       upd_target;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              fifo_full;
  logic              desync_err;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output if_valid, if_pc, if_pred_npc,
    output ex_valid, ex_pc, ex_is_ctrl, ex_taken, ex_target,
    input  upd_valid, upd_taken, upd_pc, upd_target,
    input  redirect, redirect_pc, fifo_full, desync_err,
    input  branch_cnt, mispred_cnt
  );

  modport slave (
    input  if_valid, if_pc, if_pred_npc,
    input  ex_valid, ex_pc, ex_is_ctrl, ex_taken, ex_target,
    output upd_valid, upd_taken, upd_pc, upd_target,
    output redirect, redirect_pc, fifo_full, desync_err,
    output branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/bru_track_fifo.sv
// In-order circular FIFO of prediction records.
// Ports: clk, reset (sync, active-high); clear drops all entries; push/push_rec
// write at the tail; pop retires the head; head is the oldest record; full/empty
// come from registered state only. Callers push only when !full or popping in
// the same cycle, and pop only when !empty.
module bru_track_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      push,
  input  logic      pop,
  input  pred_rec_t push_rec,
  output pred_rec_t head,
  output logic      full,
  output logic      empty
);
  pred_rec_t        mem_q [DEPTH];
  pred_rec_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) begin
        mem_d[wr_ptr_q] = push_rec;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged, even when full.
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolution side of the fetch-stage BTB / 2-bit-counter predictor.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries the IF
// record push, the EX resolve inputs, the predictor update port, the
// redirect/flush, fifo_full, sticky desync_err and saturating statistics.
// Update and redirect are combinational from EX inputs because the predictor
// samples them at the falling edge of the same cycle.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
);
  pred_rec_t       head;
  pred_rec_t       push_rec;
  logic            full, empty;
  logic            pop, push, mispredict;
  logic [XLEN-1:0] anpc;
  bp_update_t      upd;

  logic             desync_q, desync_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  assign push_rec = '{pc: bus.if_pc, pred_npc: bus.if_pred_npc};

  // Actual next PC; a stale taken BTB hit on a non-control instruction
  // mismatches against pc+4 and is redirected like any other mispredict.
  assign anpc       = (bus.ex_is_ctrl && bus.ex_taken) ? bus.ex_target
                                                       : bus.ex_pc + INSN_BYTES;
  assign mispredict = bus.ex_valid && !empty && (head.pred_npc != anpc);

  // The head record is retired even on a PC mismatch so the queue keeps
  // draining; the mismatch is reported through desync_err instead.
  assign pop  = bus.ex_valid && !empty;
  // A push in a redirect cycle is a wrong-path fetch and is discarded.
  assign push = bus.if_valid && (!full || pop) && !mispredict;

  // Training does not look at FIFO state so the predictor learns on desync.
  always_comb begin
    upd        = '0;
    upd.valid  = bus.ex_valid && bus.ex_is_ctrl;
    upd.taken  = bus.ex_valid && bus.ex_taken;
    upd.pc     = bus.ex_valid ? bus.ex_pc : '0;
    upd.target = bus.ex_valid ? bus.ex_target : '0;
  end

  always_comb begin
    desync_d      = desync_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bus.ex_valid && empty)                    desync_d = 1'b1;
    if (pop && (head.pc != bus.ex_pc))            desync_d = 1'b1;
    if (bus.if_valid && full && !pop)             desync_d = 1'b1;
    if (upd.valid && (branch_cnt_q != '1))        branch_cnt_d  = branch_cnt_q + 1'b1;
    if (mispredict && (mispred_cnt_q != '1))      mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      desync_q      <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      desync_q      <= desync_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  bru_track_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (mispredict),
    .push     (push),
    .pop      (pop),
    .push_rec (push_rec),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  assign bus.upd_valid   = upd.valid;
  assign bus.upd_taken   = upd.taken;
  assign bus.upd_pc      = upd.pc;
  assign bus.upd_target  = upd.target;
  assign bus.redirect    = mispredict;
  assign bus.redirect_pc = bus.ex_valid ? anpc : '0;
  assign bus.fifo_full   = full;
  assign bus.desync_err  = desync_q;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int RW    = 99;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pred;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.DEPTH(DEPTH), .PTR_W(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: the in-flight records as a plain queue plus counters.
  rec_t mq[$];
  bit   m_desync;
  int   m_bcnt, m_mcnt;

  logic [RW-1:0] exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   armed    = 0;

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // One clock cycle: drive inputs, queue the expected EX response, then
  // advance the model across the rising edge.
  task automatic cyc(input bit rst, input bit ifv, input logic [31:0] ipc, input logic [31:0] ipred,
                     input bit exv, input logic [31:0] epc, input bit ctrl, input bit tk,
                     input logic [31:0] tgt);
    logic [31:0] anpc;
    bit mis, popped, was_full;
    reset = rst;
    bus.if_valid = ifv; bus.if_pc = ipc; bus.if_pred_npc = ipred;
    bus.ex_valid = exv; bus.ex_pc = epc; bus.ex_is_ctrl = ctrl;
    bus.ex_taken = tk;  bus.ex_target = tgt;
    anpc = (ctrl && tk) ? tgt : epc + 32'd4;
    mis  = exv && (mq.size() > 0) && (mq[0].pred != anpc);
    if (exv && !rst)
      exp_q.push_back({(exv && ctrl), tk, epc, tgt, mis, anpc});
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_desync = 0; m_bcnt = 0; m_mcnt = 0;
    end else begin
      if (exv && ctrl) m_bcnt = (m_bcnt == CMAX) ? CMAX : m_bcnt + 1;
      if (mis)         m_mcnt = (m_mcnt == CMAX) ? CMAX : m_mcnt + 1;
      was_full = (mq.size() == DEPTH);
      popped   = exv && (mq.size() > 0);
      if (exv && mq.size() == 0) m_desync = 1;
      if (popped && mq[0].pc != epc) m_desync = 1;
      if (ifv && was_full && !popped) m_desync = 1;
      if (mis) mq.delete();
      else begin
        if (popped) void'(mq.pop_front());
        if (ifv && (!was_full || popped)) mq.push_back('{pc: ipc, pred: ipred});
      end
    end
    armed = 1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] pred);
    cyc(0, 1, pc, pred, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares the EX response whenever the DUT presents one, and the
  // registered status every cycle.
  always @(negedge clk) begin
    logic [RW-1:0] got;
    if (armed) begin
      got = {bus.upd_valid, bus.upd_taken, bus.upd_pc, bus.upd_target, bus.redirect, bus.redirect_pc};
      if (bus.ex_valid) begin
        if (exp_q.size() == 0) chk("resp_underflow", 1, 0);
        else chk("ex_resp", got, exp_q.pop_front());
      end else begin
        chk("idle_resp_zero", got, '0);
      end
      chk("fifo_full",   RW'(bus.fifo_full),   RW'(mq.size() == DEPTH));
      chk("desync_err",  RW'(bus.desync_err),  RW'(m_desync));
      chk("branch_cnt",  RW'(bus.branch_cnt),  RW'(m_bcnt));
      chk("mispred_cnt", RW'(bus.mispred_cnt), RW'(m_mcnt));
    end
  end

  initial begin
    logic [31:0] pc, pred, epc, tgt;
    bit ifv, exv, ctrl, tk;
    bus.if_valid = 0; bus.if_pc = 0; bus.if_pred_npc = 0;
    bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_is_ctrl = 0; bus.ex_taken = 0; bus.ex_target = 0;

    // Reset and idle.
    do_reset();
    idle(3);

    // Correctly predicted non-control instruction.
    push(32'h100, 32'h104);
    cyc(0, 0, 0, 0, 1, 32'h100, 0, 0, 0);
    // Taken branch predicted fall-through; same-cycle push discarded.
    push(32'h200, 32'h204);
    cyc(0, 1, 32'h204, 32'h208, 1, 32'h200, 1, 1, 32'h280);
    idle(1);
    // Not-taken branch predicted taken.
    push(32'h300, 32'h340);
    cyc(0, 0, 0, 0, 1, 32'h300, 1, 0, 32'h340);
    idle(1);

    // Fill, overflow push, then push concurrent with pop while full.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h400 + 4 * i, 32'h404 + 4 * i);
    push(32'h410, 32'h414);
    cyc(0, 1, 32'h410, 32'h414, 1, 32'h400, 0, 0, 0);
    idle(1);

    // PC mismatch at EX: record still retired, update still follows EX.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h400 + 4 * i, 32'h404 + 4 * i);
    cyc(0, 0, 0, 0, 1, 32'h500, 1, 1, 32'h404);
    idle(1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      ifv  = ($urandom_range(0, 99) < 60);
      pc   = {$urandom_range(0, 255), 2'b00};
      pred = ($urandom_range(0, 1) == 1) ? pc + 32'd4 : {$urandom_range(0, 255), 2'b00};
      exv  = ($urandom_range(0, 99) < 45);
      ctrl = $urandom_range(0, 1);
      tk   = $urandom_range(0, 1);
      epc  = (mq.size() > 0 && $urandom_range(0, 99) < 90) ? mq[0].pc : {$urandom_range(0, 255), 2'b00};
      tgt  = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].pred : {$urandom_range(0, 255), 2'b00};
      if (i % 150 == 149) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      else cyc(0, ifv, pc, pred, exv, epc, ctrl, tk, tgt);
    end

    // Saturation of both counters.
    do_reset();
    for (int i = 0; i < CMAX + 5; i++) begin
      push(32'h1000, 32'h1004);
      cyc(0, 0, 0, 0, 1, 32'h1000, 1, 1, 32'h2000);
    end
    idle(1);
    @(negedge clk);
    chk("mispred_sat", RW'(bus.mispred_cnt), RW'(8'hFF));
    chk("branch_sat",  RW'(bus.branch_cnt),  RW'(8'hFF));

    idle(2);
    chk("exp_q_drained", RW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
